datastore_buf: RTL
==================

# datastore_buf

Parametrised keyboard digit store: the successor to the fixed 32-nibble key/plaintext register. It accepts hex digits from the PS/2 scan-to-hex path and writes them into a DEPTH-entry store, in either direct-indexed or auto-append mode. Append mode adds a fill counter, backspace, clear, overflow flag and a lock/commit handshake. The flattened store feeds the A5/1 encrypt/decrypt datapath, which consumes it only after `locked` is asserted.

## Interface
- `DIGIT_W`, default 4: bits per digit.
- `DEPTH`, default 32: number of digit slots. Must be ≥2.
- `IDX_W`, default 5: index width. Must satisfy ceil(log2(DEPTH)) ≤ IDX_W.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `digit_in`  in  DIGIT_W: digit to store.
- `index`  in  IDX_W: target slot for a direct write (mode=0).
- `mode`  in  1: 0 = direct-indexed write, 1 = auto-append.
- `write_enable`  in  1: write request, sampled each cycle.
- `backspace`  in  1: remove the last appended digit (mode=1 only).
- `clear`  in  1: synchronous clear of store, count and flags.
- `lock`  in  1: commit the contents; blocks edits until `clear`.
- `datastore_out`  out  DIGIT_W*DEPTH: slot i occupies bits [i*DIGIT_W +: DIGIT_W].
- `count`  out  IDX_W+1: number of filled slots (high-water mark).
- `empty`, `full`  out  1 each: count==0, count==DEPTH.
- `overflow`  out  1: sticky; set by an append attempted while full.
- `locked`  out  1: high in state LOCKED.
- `done`  out  1: one-cycle pulse on the cycle after a lock is accepted.

## Operation
- States: EDIT and LOCKED. Reset enters EDIT.
- Only one action is accepted per cycle. Priority: clear > lock > backspace > write_enable.
- clear (either state): all slots go to 0, count to 0, overflow to 0, state to EDIT. done does not pulse.
- lock in EDIT: state goes to LOCKED, and done pulses for 1 cycle. Lock while LOCKED is ignored, with no second done pulse.
- In LOCKED, write_enable and backspace are ignored. The store, count and flags hold.
- Direct write (EDIT, mode=0, write_enable):
  - slot[index] ← digit_in; no other slot changes.
  - count ← max(count, index+1).
  - If index ≥ DEPTH, the write is dropped. Nothing changes and overflow is not set.
- Append (EDIT, mode=1, write_enable):
  - If count<DEPTH: slot[count] ← digit_in and count increments.
  - If full: the store and count are unchanged and overflow ← 1.
- Backspace (EDIT, mode=1):
  - If count>0: count decrements and slot[count-1] ← 0.
  - If empty: no effect.
  - Backspace with mode=0 is ignored.
- mode may change between any two cycles. Append always uses the current count, including a count raised by earlier direct writes.
- count arithmetic is unsigned, IDX_W+1 bits. It never exceeds DEPTH and never wraps below 0.

## Timing
- All state updates occur on the rising edge of clk. Outputs are registered, except that empty and full are decoded from count.
- Write-to-output latency: 1 cycle. The digit appears on datastore_out the cycle after write_enable is sampled.
- lock sampled at edge N: locked is high after N. done is high for the cycle after N and low the cycle after that.
- reset asserted at any time, including mid-append or in LOCKED, takes effect immediately. datastore_out=0, count=0, empty=1, full=0, overflow=0, locked=0, done=0.
- Release of reset is synchronous in effect: the first accepted action is at the first rising edge with reset low.
- Simultaneous events in the same cycle:
  - write_enable with backspace: backspace wins, and the digit is discarded.
  - lock with write_enable: lock wins, and the digit is not stored.
  - clear with anything: clear wins.

## Test plan
- Reset, then append 0x1,0x2,0x3 (mode=1) → datastore_out[11:0]=0x321, count=3, empty=0, full=0.
- Append 32 digits 0xF, then one more 0xA → full=1, count=32, overflow=1, datastore_out=all 1s. Then clear → all outputs at reset values.
- Append 0xA,0xB; backspace; append 0xC → bits[7:0]=0xCA, count=2. Backspace ×3 from count=2 → count=0, bits[7:0]=0x00, no underflow.
- mode=0: write 0x7 at index 5 → bits[23:20]=0x7, count=6, other slots 0. Then mode=1 append 0x9 → bits[27:24]=0x9, count=7.
- lock at cycle N → locked=1 and done=1 at N+1 only. Writes and backspaces while locked leave datastore_out unchanged. lock+write_enable in the same cycle stores nothing.
- Assert reset asynchronously mid-sequence at count=10 in LOCKED → all outputs go to 0 (empty=1) before the next clock edge. The first append after release writes slot 0.

Source files
------------

// File: rtl/datastore_buf.sv
// Keyboard digit store: DEPTH slots of DIGIT_W bits, filled by direct-indexed or
// auto-append writes, with backspace, clear, sticky overflow and a lock/commit handshake.
module datastore_buf #(
    parameter int DIGIT_W = 4,
    parameter int DEPTH   = 32,
    parameter int IDX_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIGIT_W-1:0]       digit_in,
    input  logic [IDX_W-1:0]         index,
    input  logic                     mode,
    input  logic                     write_enable,
    input  logic                     backspace,
    input  logic                     clear,
    input  logic                     lock,
    output logic [DIGIT_W*DEPTH-1:0] datastore_out,
    output logic [IDX_W:0]           count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     locked,
    output logic                     done
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {
        EDIT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_next;
    logic [CNT_W-1:0]     count_q, count_next;
    logic                 overflow_q, overflow_next;
    logic                 done_q, done_next;

    logic [DIGIT_W-1:0]   slot_q [DEPTH];

    // Single write port into the store, shared by direct writes, appends and backspace.
    logic                 clear_all;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [DIGIT_W-1:0]   wr_data;

    logic [CNT_W-1:0]     index_ext;
    logic                 is_empty;
    logic                 is_full;

    assign index_ext = {1'b0, index};
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == DEPTH_C);

    // Next-state decode; one action per cycle with clear > lock > backspace > write.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a variable unassigned and no latch is inferred.
        state_next    = state_q;
        count_next    = count_q;
        overflow_next = overflow_q;
        done_next     = 1'b0;
        clear_all     = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = '0;
        wr_data       = '0;

        if (clear) begin
            clear_all     = 1'b1;
            state_next    = EDIT;
            count_next    = '0;
            overflow_next = 1'b0;
        end else if (state_q == EDIT) begin
            if (lock) begin
                state_next = LOCKED;
                done_next  = 1'b1;
            end else if (backspace) begin
                // Backspace consumes the cycle even in direct mode, where it is a no-op.
                if (mode && !is_empty) begin
                    count_next = count_q - ONE_C;
                    wr_en      = 1'b1;
                    wr_idx     = IDX_W'(count_q - ONE_C);
                    wr_data    = '0;
                end
            end else if (write_enable) begin
                if (!mode) begin
                    if (index_ext < DEPTH_C) begin
                        wr_en   = 1'b1;
                        wr_idx  = index;
                        wr_data = digit_in;
                        if (index_ext >= count_q) begin
                            count_next = index_ext + ONE_C;
                        end
                    end
                end else if (!is_full) begin
                    wr_en      = 1'b1;
                    wr_idx     = IDX_W'(count_q);
                    wr_data    = digit_in;
                    count_next = count_q + ONE_C;
                end else begin
                    overflow_next = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EDIT;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_next;
            count_q    <= count_next;
            overflow_q <= overflow_next;
            done_q     <= done_next;
        end
    end

    // NOTE: the store is a flop array, not a RAM, because both reset and clear
    // must zero every slot at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    slot_q[i] <= wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flatten
        assign datastore_out[g*DIGIT_W +: DIGIT_W] = slot_q[g];
    end

    assign count    = count_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign overflow = overflow_q;
    assign locked   = (state_q == LOCKED);
    assign done     = done_q;

endmodule
